// File: rtl/otter_bp_pkg.sv
// Shared definitions for the OTTER dynamic branch predictor.
//
// Contents:
//   clog2        - index-width helper, usable in constant expressions
//   bp_entry_t   - one BTB/direction-table entry, packed
//   ctr_weak_t   - weakly-taken counter value for a given counter width
//   ctr_weak_nt  - weakly-not-taken counter value for a given counter width
//   CTR_WEAK_T / CTR_WEAK_NT - the above for the default 2-bit counter
//
// The entry fields are sized for the largest legal configuration: 4-bit
// counters and the tag left over by the smallest table (4 entries).
// Narrower configurations store their fields zero-extended, so one entry
// type serves every parameterisation of the predictor.
package otter_bp_pkg;

    localparam int TAG_MAX_W    = 28;  // 32 - log2(4) - 2
    localparam int CTR_MAX_W    = 4;
    localparam int CTR_BITS_DEF = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic                 is_jump;
        logic [CTR_MAX_W-1:0] ctr;
    } bp_entry_t;

    function automatic logic [CTR_MAX_W-1:0] ctr_weak_t(input int bits);
        return CTR_MAX_W'(1) << (bits - 1);
    endfunction

    function automatic logic [CTR_MAX_W-1:0] ctr_weak_nt(input int bits);
        return ctr_weak_t(bits) - CTR_MAX_W'(1);
    endfunction

    localparam logic [CTR_MAX_W-1:0] CTR_WEAK_T  = ctr_weak_t(CTR_BITS_DEF);
    localparam logic [CTR_MAX_W-1:0] CTR_WEAK_NT = ctr_weak_nt(CTR_BITS_DEF);

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-value logic for a W-bit saturating up/down counter.
//
// Ports:
//   cur  in  W  current counter value
//   inc  in  1  1 = count up, 0 = count down
//   nxt  out W  next value, clamped to 0 and 2^W-1
module bp_sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (inc) begin
            if (cur != {W{1'b1}}) nxt = cur + W'(1);
        end else begin
            if (cur != {W{1'b0}}) nxt = cur - W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the OTTER fetch stage: a direct-mapped BTB
// whose entries also carry a saturating direction counter.
//
// Fetch side (combinational, zero latency):
//   IF_PC         in  32      PC being fetched
//   PRED_TAKEN    out 1       hit && (is_jump || counter MSB)
//   PRED_NEXT_PC  out 32      stored target when taken, else IF_PC+4 (wraps)
//   PRED_GHR      out HIST_W  history used for this lookup (0 in bimodal)
// Execute side (trains on the rising edge where UPD_VALID=1):
//   UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET, UPD_IS_JUMP, UPD_GHR
//   FLUSH         in  1       clears every valid bit; drops a same-cycle update
// Clock/reset: CLK rising edge, RST asynchronous active-high.
//
// Parameters: ENTRIES (power of two, >=4), CTR_BITS (2..4),
// MODE (0 bimodal, 1 gshare), HIST_W (<= log2(ENTRIES)).
//
// Interface contract: there is no handshake. A prediction is valid for
// IF_PC in the same cycle; an update is accepted unconditionally on the
// edge where UPD_VALID=1 and is first visible to lookups in the next cycle
// (no same-cycle bypass).
module branch_predictor
    import otter_bp_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int MODE     = 0,
    parameter int HIST_W   = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       IF_PC,
    output logic              PRED_TAKEN,
    output logic [31:0]       PRED_NEXT_PC,
    output logic [HIST_W-1:0] PRED_GHR,
    input  logic              UPD_VALID,
    input  logic [31:0]       UPD_PC,
    input  logic              UPD_TAKEN,
    input  logic [31:0]       UPD_TARGET,
    input  logic              UPD_IS_JUMP,
    input  logic [HIST_W-1:0] UPD_GHR,
    input  logic              FLUSH
);

    localparam int IDX_W = clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [CTR_MAX_W-1:0] WEAK_T  = ctr_weak_t(CTR_BITS);
    localparam logic [CTR_MAX_W-1:0] WEAK_NT = ctr_weak_nt(CTR_BITS);

    bp_entry_t          table_q [ENTRIES];
    // Kept apart from the entries so reset and FLUSH clear them in one edge.
    logic [ENTRIES-1:0] valid_q;
    logic [HIST_W-1:0]  ghr_q;

    // PC[1:0] is always zero for 4-byte instructions.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{IF_PC[1:0], UPD_PC[1:0]};

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] idx_l;
    logic [TAG_W-1:0] tag_l;
    bp_entry_t        e_l;
    logic             hit_l;

    // ghr_q is held at zero in bimodal mode, so the XOR is a no-op there.
    assign idx_l = IF_PC[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign tag_l = IF_PC[31:IDX_W+2];
    assign e_l   = table_q[idx_l];
    assign hit_l = valid_q[idx_l] && e_l.valid && (e_l.tag == TAG_MAX_W'(tag_l));

    // Stored counters never exceed 2^CTR_BITS-1, so ">= weakly taken" is the MSB test.
    assign PRED_TAKEN   = hit_l && (e_l.is_jump || (e_l.ctr >= WEAK_T));
    assign PRED_NEXT_PC = PRED_TAKEN ? e_l.target : (IF_PC + 32'd4);
    assign PRED_GHR     = ghr_q;

    // ---------------- update ----------------
    logic [IDX_W-1:0]    idx_u;
    logic [TAG_W-1:0]    tag_u;
    logic                hit_u;
    logic [CTR_BITS-1:0] ctr_cur;
    logic [CTR_BITS-1:0] ctr_nxt;

    assign idx_u   = UPD_PC[IDX_W+1:2] ^ ((MODE == 1) ? IDX_W'(UPD_GHR) : IDX_W'(0));
    assign tag_u   = UPD_PC[31:IDX_W+2];
    assign hit_u   = valid_q[idx_u] && table_q[idx_u].valid
                     && (table_q[idx_u].tag == TAG_MAX_W'(tag_u));
    assign ctr_cur = table_q[idx_u].ctr[CTR_BITS-1:0];

    bp_sat_counter #(.W(CTR_BITS)) u_ctr (
        .cur (ctr_cur),
        .inc (UPD_TAKEN),
        .nxt (ctr_nxt)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            ghr_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0,
                                is_jump: 1'b0, ctr: WEAK_NT};
            end
        end else if (FLUSH) begin
            // Counters and history survive a flush; only the valid bits go.
            valid_q <= '0;
        end else if (UPD_VALID) begin
            if (hit_u) begin
                table_q[idx_u].ctr     <= CTR_MAX_W'(ctr_nxt);
                table_q[idx_u].is_jump <= UPD_IS_JUMP;
                if (UPD_TAKEN) table_q[idx_u].target <= UPD_TARGET;
            end else if (UPD_TAKEN) begin
                // Allocation overwrites whatever aliased into this slot.
                table_q[idx_u] <= '{valid: 1'b1, tag: TAG_MAX_W'(tag_u),
                                    target: UPD_TARGET, is_jump: UPD_IS_JUMP,
                                    ctr: WEAK_T};
                valid_q[idx_u] <= 1'b1;
            end
            // Non-speculative history: only resolved conditional branches shift.
            if ((MODE == 1) && !UPD_IS_JUMP) begin
                ghr_q <= (ghr_q << 1) | HIST_W'(UPD_TAKEN);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed test of branch_predictor in bimodal (instance a) and gshare
// (instance b) configurations. Drivers push the expected lookup response
// into a per-instance queue and raise a check strobe; a monitor on the
// falling edge pops and compares.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance a: bimodal
    logic [31:0] a_if_pc, a_pred_next_pc, a_upd_pc, a_upd_target;
    logic        a_pred_taken, a_upd_valid, a_upd_taken, a_upd_is_jump, a_flush, a_chk;
    logic [5:0]  a_pred_ghr, a_upd_ghr;
    // instance b: gshare
    logic [31:0] b_if_pc, b_pred_next_pc, b_upd_pc, b_upd_target;
    logic        b_pred_taken, b_upd_valid, b_upd_taken, b_upd_is_jump, b_flush, b_chk;
    logic [5:0]  b_pred_ghr, b_upd_ghr;

    branch_predictor #(.ENTRIES(64), .CTR_BITS(2), .MODE(0), .HIST_W(6)) u_bimodal (
        .CLK(clk), .RST(rst), .IF_PC(a_if_pc), .PRED_TAKEN(a_pred_taken),
        .PRED_NEXT_PC(a_pred_next_pc), .PRED_GHR(a_pred_ghr), .UPD_VALID(a_upd_valid),
        .UPD_PC(a_upd_pc), .UPD_TAKEN(a_upd_taken), .UPD_TARGET(a_upd_target),
        .UPD_IS_JUMP(a_upd_is_jump), .UPD_GHR(a_upd_ghr), .FLUSH(a_flush)
    );

    branch_predictor #(.ENTRIES(64), .CTR_BITS(2), .MODE(1), .HIST_W(6)) u_gshare (
        .CLK(clk), .RST(rst), .IF_PC(b_if_pc), .PRED_TAKEN(b_pred_taken),
        .PRED_NEXT_PC(b_pred_next_pc), .PRED_GHR(b_pred_ghr), .UPD_VALID(b_upd_valid),
        .UPD_PC(b_upd_pc), .UPD_TAKEN(b_upd_taken), .UPD_TARGET(b_upd_target),
        .UPD_IS_JUMP(b_upd_is_jump), .UPD_GHR(b_upd_ghr), .FLUSH(b_flush)
    );

    // expected word: {taken, next_pc[31:0], ghr[5:0]}
    logic [38:0] exp_a_q[$];
    logic [38:0] exp_b_q[$];
    string       name_a_q[$];
    string       name_b_q[$];
    int          total = 0;
    int          bad   = 0;

    // ---------------- scoreboard / monitor ----------------
    task automatic score(input bit sel, input logic [38:0] act);
        logic [38:0] exp;
        string       nm;
        total++;
        if ((sel ? exp_b_q.size() : exp_a_q.size()) == 0) begin
            bad++;
            $display("FAIL underflow_%0d: response with no expected entry, got %h", sel, act);
        end else begin
            if (sel) begin exp = exp_b_q.pop_front(); nm = name_b_q.pop_front(); end
            else     begin exp = exp_a_q.pop_front(); nm = name_a_q.pop_front(); end
            if (act !== exp) begin
                bad++;
                $display("FAIL %s: got taken=%0b next=%h ghr=%b, want taken=%0b next=%h ghr=%b",
                         nm, act[38], act[37:6], act[5:0], exp[38], exp[37:6], exp[5:0]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (a_chk) score(1'b0, {a_pred_taken, a_pred_next_pc, a_pred_ghr});
        if (b_chk) score(1'b1, {b_pred_taken, b_pred_next_pc, b_pred_ghr});
    end

    // ---------------- drivers ----------------
    task automatic push_exp(input bit sel, input string nm, input logic t,
                            input logic [31:0] nxt, input logic [5:0] g);
        if (sel) begin exp_b_q.push_back({t, nxt, g}); name_b_q.push_back(nm); end
        else     begin exp_a_q.push_back({t, nxt, g}); name_a_q.push_back(nm); end
    endtask

    task automatic upd(input bit sel, input logic [31:0] pc, input logic taken,
                       input logic [31:0] target, input logic is_jump,
                       input logic [5:0] ghr, input logic flush);
        @(posedge clk); #1;
        if (sel) begin
            b_upd_pc = pc; b_upd_taken = taken; b_upd_target = target;
            b_upd_is_jump = is_jump; b_upd_ghr = ghr; b_flush = flush; b_upd_valid = 1'b1;
        end else begin
            a_upd_pc = pc; a_upd_taken = taken; a_upd_target = target;
            a_upd_is_jump = is_jump; a_upd_ghr = ghr; a_flush = flush; a_upd_valid = 1'b1;
        end
        @(posedge clk); #1;
        a_upd_valid = 1'b0; a_flush = 1'b0;
        b_upd_valid = 1'b0; b_flush = 1'b0;
    endtask

    task automatic expect_lookup(input bit sel, input string nm, input logic [31:0] pc,
                                 input logic t, input logic [31:0] nxt, input logic [5:0] g);
        @(posedge clk); #1;
        if (sel) b_if_pc = pc; else a_if_pc = pc;
        push_exp(sel, nm, t, nxt, g);
        if (sel) b_chk = 1'b1; else a_chk = 1'b1;
        @(negedge clk); #1;
        a_chk = 1'b0; b_chk = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        a_if_pc = '0; a_upd_valid = 0; a_upd_pc = '0; a_upd_taken = 0; a_upd_target = '0;
        a_upd_is_jump = 0; a_upd_ghr = '0; a_flush = 0; a_chk = 0;
        b_if_pc = '0; b_upd_valid = 0; b_upd_pc = '0; b_upd_taken = 0; b_upd_target = '0;
        b_upd_is_jump = 0; b_upd_ghr = '0; b_flush = 0; b_chk = 0;

        expect_lookup(0, "rst_a", 32'h100, 0, 32'h104, 6'd0);
        expect_lookup(1, "rst_b", 32'h100, 0, 32'h104, 6'd0);
        @(posedge clk); #1 rst = 1'b0;
        expect_lookup(0, "pc_wrap", 32'hFFFF_FFFC, 0, 32'h0, 6'd0);

        // bimodal counter training on 0x100 (index 0)
        upd(0, 32'h100, 1, 32'h200, 0, 6'd0, 0);                      // alloc, ctr 2
        expect_lookup(0, "alloc_taken", 32'h100, 1, 32'h200, 6'd0);
        upd(0, 32'h100, 0, 32'h0, 0, 6'd0, 0);                        // ctr 1
        expect_lookup(0, "ctr_down_1", 32'h100, 0, 32'h104, 6'd0);
        for (int i = 0; i < 3; i++) upd(0, 32'h100, 1, 32'h200, 0, 6'd0, 0); // 2,3,3
        expect_lookup(0, "ctr_sat_3", 32'h100, 1, 32'h200, 6'd0);
        upd(0, 32'h100, 0, 32'h0, 0, 6'd0, 0);                        // ctr 2
        expect_lookup(0, "ctr_back_2", 32'h100, 1, 32'h200, 6'd0);
        upd(0, 32'h100, 0, 32'h0, 0, 6'd0, 0);                        // ctr 1
        expect_lookup(0, "ctr_back_1", 32'h100, 0, 32'h104, 6'd0);

        // aliasing: 0x300 shares index 0 with 0x100
        upd(0, 32'h100, 1, 32'h200, 0, 6'd0, 0);                      // ctr 2
        expect_lookup(0, "retrain", 32'h100, 1, 32'h200, 6'd0);
        expect_lookup(0, "alias_miss", 32'h300, 0, 32'h304, 6'd0);
        upd(0, 32'h300, 1, 32'h400, 0, 6'd0, 0);
        expect_lookup(0, "alias_alloc", 32'h300, 1, 32'h400, 6'd0);
        expect_lookup(0, "alias_evicted", 32'h100, 0, 32'h104, 6'd0);

        // jump: taken regardless of counter, even after driving it to 0
        upd(0, 32'h180, 1, 32'h40, 1, 6'd0, 0);
        expect_lookup(0, "jump_taken", 32'h180, 1, 32'h40, 6'd0);
        upd(0, 32'h180, 0, 32'h0, 1, 6'd0, 0);
        upd(0, 32'h180, 0, 32'h0, 1, 6'd0, 0);
        expect_lookup(0, "jump_ctr0", 32'h180, 1, 32'h40, 6'd0);

        // same-cycle update and lookup: no bypass
        @(posedge clk); #1;
        a_upd_pc = 32'h100; a_upd_taken = 1; a_upd_target = 32'h200; a_upd_is_jump = 0;
        a_upd_valid = 1; a_if_pc = 32'h100;
        push_exp(0, "no_bypass", 0, 32'h104, 6'd0);
        a_chk = 1;
        @(negedge clk); #1 a_chk = 0;
        @(posedge clk); #1 a_upd_valid = 0;
        push_exp(0, "visible_next", 1, 32'h200, 6'd0);
        a_chk = 1;
        @(negedge clk); #1 a_chk = 0;

        // flush beats a same-cycle update
        upd(0, 32'h104, 1, 32'h700, 0, 6'd0, 1);
        expect_lookup(0, "flush_100", 32'h100, 0, 32'h104, 6'd0);
        expect_lookup(0, "flush_180", 32'h180, 0, 32'h184, 6'd0);
        expect_lookup(0, "flush_drop", 32'h104, 0, 32'h108, 6'd0);

        // asynchronous reset in the middle of a cycle
        upd(0, 32'h100, 1, 32'h200, 0, 6'd0, 0);
        expect_lookup(0, "pre_rst", 32'h100, 1, 32'h200, 6'd0);
        @(posedge clk); #1 a_if_pc = 32'h100;
        #2 rst = 1'b1;
        push_exp(0, "async_rst", 0, 32'h104, 6'd0);
        a_chk = 1;
        @(negedge clk); #1 a_chk = 0;
        @(posedge clk); #1 rst = 1'b0;
        expect_lookup(0, "post_rst", 32'h100, 0, 32'h104, 6'd0);

        // gshare: history T,T,NT -> 0b000110
        upd(1, 32'h800, 1, 32'h880, 0, 6'd0, 0);                      // alloc idx 0, ctr 2
        upd(1, 32'h800, 1, 32'h880, 0, 6'd0, 0);                      // ctr 3
        upd(1, 32'h800, 0, 32'h0, 0, 6'd0, 0);                        // ctr 2
        expect_lookup(1, "ghr_110", 32'h100, 0, 32'h104, 6'b000110);
        // jump trains index 0^6 without shifting history
        upd(1, 32'h100, 1, 32'h900, 1, 6'b000110, 0);
        expect_lookup(1, "gshare_hit", 32'h100, 1, 32'h900, 6'b000110);
        upd(1, 32'hA00, 0, 32'h0, 0, 6'd0, 0);                        // ghr 001100
        expect_lookup(1, "ghr_shift", 32'h100, 0, 32'h104, 6'b001100);
        for (int i = 0; i < 5; i++) upd(1, 32'hA00, 0, 32'h0, 0, 6'd0, 0);
        expect_lookup(1, "gshare_miss", 32'h100, 0, 32'h104, 6'd0);
        expect_lookup(1, "gshare_idx0", 32'h800, 1, 32'h880, 6'd0);

        repeat (2) @(posedge clk);
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: leftover a=%0d b=%0d, want 0 0", exp_a_q.size(), exp_b_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
